// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the operand-memory stream reader.
package mem_stream_reader_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Small synchronous FIFO holding returned read data plus its last flag; head is visible the
// cycle after push, push is ignored when full, pop is ignored when empty.
module mem_stream_reader_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Issues LENGTH sequential reads to a 1-cycle RAM and streams the words out with a last marker.
// start -> first m_valid in 3 cycles; issue stalls when FIFO plus in-flight read reach FIFO_DEPTH.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, idx_q, idx_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;

  logic                    issue, last_issue, accept;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [FIFO_CNT_W:0]     occupancy;
  logic                    fifo_empty, fifo_full;
  logic [DATA_WIDTH:0]     fifo_head;

  mem_stream_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_data_out}),
    .pop       (accept),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (fifo_head)
  );

  // Issue decision looks only at registered state, keeping m_ready off the RAM path.
  assign occupancy  = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(inflight_q);
  assign issue      = (state_q == ST_RUN) && !fifo_full &&
                      (occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
  assign last_issue = issue && (remaining_q == (ADDR_WIDTH + 1)'(1));
  assign accept     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      idx_q           <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      idx_q           <= idx_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (accept && m_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_d          = base_q;
    idx_d           = idx_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    if (state_q == ST_IDLE && start) begin
      base_d      = base_addr;
      idx_d       = '0;
      remaining_d = length;
    end else if (issue) begin
      idx_d       = idx_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_comb begin
    busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done             = (state_q == ST_DONE);
    mem_read_en      = issue;
    mem_read_address = base_q + idx_q;
    m_valid          = !fifo_empty;
    m_data           = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    m_last           = !fifo_empty && fifo_head[DATA_WIDTH];
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a preloaded 1-cycle registered-read RAM.
module tb_mem_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, mem_read_en, m_valid, m_last, m_ready;
  logic [3:0] base_addr, mem_read_address;
  logic [4:0] length;
  logic [7:0] mem_data_out, m_data;

  always #5 clk = ~clk;

  mem_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_read_en(mem_read_en), .mem_read_address(mem_read_address),
    .mem_data_out(mem_data_out), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready)
  );

  logic [7:0] ram [16];
  initial for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
  initial mem_data_out = 8'h00;
  always @(posedge clk) if (mem_read_en) mem_data_out <= ram[mem_read_address];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_data [$];
  bit         got_last [$];
  int         got_cyc  [$];
  logic [3:0] rd_addr  [$];
  int         rd_cyc   [$];
  bit         busy_hist[$];
  int         done_cyc, max_out;
  bit         stall_bad, busy_bad, post_busy, post_en;

  // Starts a vector and records everything observable until done or the cycle budget runs out.
  // mode 0: ready high; 1: ready toggles; 2: conflicting start mid-run; 3: start held high.
  task automatic run_vec(input logic [3:0] b, input logic [4:0] l, input int mode, input int budget);
    int nrd, nacc;
    bit pv, pr, pl;
    logic [7:0] pd;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    rd_addr.delete(); rd_cyc.delete(); busy_hist.delete();
    done_cyc = -1; max_out = 0; stall_bad = 0; busy_bad = 0;
    nrd = 0; nacc = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    base_addr = b; length = l; start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (c == 1 && mode != 3) start = 1'b0;
      if (mode == 2 && c == 2) begin start = 1'b1; base_addr = 4'd9; length = 5'd1; end
      if (mode == 2 && c == 3) start = 1'b0;
      m_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
      #1;
      busy_hist.push_back(busy);
      if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stall_bad = 1;
      if (mem_read_en) begin
        rd_addr.push_back(mem_read_address); rd_cyc.push_back(c); nrd++;
        if (nrd - nacc > max_out) max_out = nrd - nacc;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data); got_last.push_back(m_last); got_cyc.push_back(c); nacc++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (done) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
    if (mode != 3) start = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    post_busy = busy; post_en = mem_read_en;
    if (done_cyc >= 0)
      for (int c = 0; c < busy_hist.size(); c++)
        if (busy_hist[c] !== (c >= 1 && c < done_cyc)) busy_bad = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; base_addr = 4'd0; length = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, mem_read_en, m_valid, m_last} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, mem_read_en, m_valid, m_last});
    end
    n_checks++;
    if (mem_read_address !== 4'h0 || m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr_data: got addr %h data %h want 0 00", mem_read_address, m_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_vec(4'd2, 5'd3, 0, 30);
    n_checks++;
    if (got_data.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      n_checks++;
      if (got_data[i] !== 8'h12 + 8'(i) || got_last[i] !== (i == 2) || got_cyc[i] != 3 + i) begin
        n_fail++;
        $display("FAIL basic_elem%0d: got data %h last %0d cyc %0d want %h %0d %0d",
                 i, got_data[i], got_last[i], got_cyc[i], 8'h12 + 8'(i), (i == 2), 3 + i);
      end
    end
    n_checks++;
    if (rd_addr.size() != 3 || rd_addr[0] !== 4'd2 || rd_cyc[0] != 1) begin
      n_fail++; $display("FAIL basic_reads: got %0d reads, first cyc %0d want 3 reads first cyc 1", rd_addr.size(), rd_cyc[0]);
    end
    n_checks++;
    if (done_cyc != 6) begin n_fail++; $display("FAIL basic_done: got cycle %0d want 6", done_cyc); end
    n_checks++;
    if (busy_bad) begin n_fail++; $display("FAIL basic_busy: got busy window wrong want cycles 1..5"); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4] = '{8'h1E, 8'h1F, 8'h10, 8'h11};
    logic [3:0] exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    run_vec(4'd14, 5'd4, 0, 30);
    n_checks++;
    if (got_data.size() != 4 || rd_addr.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d elems %0d reads want 4 4", got_data.size(), rd_addr.size());
    end
    for (int i = 0; i < got_data.size() && i < 4 && i < rd_addr.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_d[i] || rd_addr[i] !== exp_a[i] || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_elem%0d: got data %h addr %0d last %0d want %h %0d %0d",
                 i, got_data[i], rd_addr[i], got_last[i], exp_d[i], exp_a[i], (i == 3));
      end
    end
    n_checks++;
    if (done_cyc != 7) begin n_fail++; $display("FAIL wrap_done: got cycle %0d want 7", done_cyc); end
  endtask

  task automatic test_backpressure();
    run_vec(4'd3, 5'd8, 1, 100);
    n_checks++;
    if (got_data.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      n_checks++;
      if (got_data[i] !== 8'h13 + 8'(i) || got_last[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL bp_elem%0d: got %h last %0d want %h %0d", i, got_data[i], got_last[i], 8'h13 + 8'(i), (i == 7));
      end
    end
    n_checks++;
    if (stall_bad) begin n_fail++; $display("FAIL bp_stable: got output change during stall want stable"); end
    n_checks++;
    if (max_out > 4) begin n_fail++; $display("FAIL bp_outstanding: got %0d want <= 4", max_out); end
    n_checks++;
    if (got_cyc.size() != 8 || done_cyc != got_cyc[7] + 1) begin
      n_fail++; $display("FAIL bp_done: got cycle %0d want one after last handshake", done_cyc);
    end
  endtask

  task automatic test_zero_length();
    run_vec(4'd7, 5'd0, 0, 10);
    n_checks++;
    if (rd_addr.size() != 0 || got_data.size() != 0) begin
      n_fail++; $display("FAIL zero_traffic: got %0d reads %0d elems want 0 0", rd_addr.size(), got_data.size());
    end
    n_checks++;
    if (done_cyc != 1 || busy_bad) begin
      n_fail++; $display("FAIL zero_done: got done cycle %0d busy_bad %0d want 1 0", done_cyc, busy_bad);
    end
  endtask

  task automatic test_full_length();
    logic [3:0] a;
    run_vec(4'd5, 5'd16, 0, 60);
    n_checks++;
    if (got_data.size() != 16 || rd_addr.size() != 16) begin
      n_fail++; $display("FAIL full_count: got %0d elems %0d reads want 16 16", got_data.size(), rd_addr.size());
    end
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      a = 4'(5 + i);
      n_checks++;
      if (got_data[i] !== 8'h10 + 8'(a) || got_last[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL full_elem%0d: got %h last %0d want %h %0d", i, got_data[i], got_last[i], 8'h10 + 8'(a), (i == 15));
      end
    end
    n_checks++;
    if (done_cyc != 19) begin n_fail++; $display("FAIL full_done: got cycle %0d want 19", done_cyc); end
  endtask

  task automatic test_ignore_start();
    run_vec(4'd2, 5'd3, 2, 30);
    n_checks++;
    if (got_data.size() != 3 || got_data[0] !== 8'h12 || got_data[2] !== 8'h14 || got_last[2] !== 1'b1) begin
      n_fail++; $display("FAIL ignore_busy: got %0d elems first %h want 3 elems 12..14", got_data.size(), got_data[0]);
    end
    n_checks++;
    if (done_cyc != 6) begin n_fail++; $display("FAIL ignore_done: got cycle %0d want 6", done_cyc); end
    run_vec(4'd4, 5'd2, 3, 30);
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 8'h14 || got_data[1] !== 8'h15 || done_cyc != 5) begin
      n_fail++; $display("FAIL ignore_held: got %0d elems done %0d want 2 elems 14,15 done 5", got_data.size(), done_cyc);
    end
    n_checks++;
    if (post_busy !== 1'b0 || post_en !== 1'b0) begin
      n_fail++; $display("FAIL ignore_in_done: got busy %0d en %0d after done want 0 0", post_busy, post_en);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit saw;
    base_addr = 4'd0; length = 5'd3; start = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1 || mem_read_en !== 1'b0 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_state: got busy %0d en %0d valid %0d want 1 0 1", busy, mem_read_en, m_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, mem_read_en, m_valid, m_last} !== 5'b0 || m_data !== 8'h00 || mem_read_address !== 4'h0) begin
      n_fail++; $display("FAIL abort_outputs: got flags %b data %h addr %h want 00000 00 0",
                         {busy, done, mem_read_en, m_valid, m_last}, m_data, mem_read_address);
    end
    rst_n = 1'b1; m_ready = 1'b1; saw = 0;
    repeat (6) begin @(posedge clk); #1; if (done || m_valid) saw = 1; end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL abort_quiet: got done or valid after abort want none"); end
    run_vec(4'd3, 5'd2, 0, 30);
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 8'h13 || got_data[1] !== 8'h14 || got_last[1] !== 1'b1 || done_cyc != 5) begin
      n_fail++; $display("FAIL abort_restart: got %0d elems done %0d want 2 elems 13,14 done 5", got_data.size(), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_full_length();
    test_ignore_start();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
